// File: rtl/coding_bit_serializer_if.sv
// Handshake bundle between the word source, the bit serializer and coding_queue.
// The master side drives words and back-pressure; the slave side is the serializer.
interface coding_bit_serializer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             queue_full;
    logic             bit_output;
    logic             wrreq;
    logic             busy;
    logic             word_done;

    modport master (
        output data_in,
        output data_valid,
        output queue_full,
        input  data_ready,
        input  bit_output,
        input  wrreq,
        input  busy,
        input  word_done
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  queue_full,
        output data_ready,
        output bit_output,
        output wrreq,
        output busy,
        output word_done
    );
endinterface

// File: rtl/coding_bit_serializer.sv
// Parallel-to-serial front end for coding_queue: one bit per clock, stalls on
// queue_full, and a one-word holding register so back-to-back words stream gap-free.
module coding_bit_serializer #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    coding_bit_serializer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hold_valid_q, hold_valid_d;
    logic             word_done_q, word_done_d;

    logic accept;
    logic last;
    logic free;

    assign bus.data_ready = !hold_valid_q;
    assign bus.wrreq      = (state_q == SHIFT) && !bus.queue_full;
    assign bus.busy       = (state_q == SHIFT) || hold_valid_q;
    assign bus.word_done  = word_done_q;
    assign bus.bit_output = (state_q == SHIFT) ?
                            (LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1]) : 1'b0;

    assign accept = bus.data_valid && !hold_valid_q;
    assign last   = bus.wrreq && (cnt_q == LAST_CNT);
    assign free   = (state_q == IDLE) || last;

    // A finishing word hands sreg to the held word first, else to an incoming one
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        hold_valid_d = hold_valid_q;
        word_done_d  = last;

        if (bus.wrreq && !last) begin
            sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
            cnt_d  = cnt_q + CW'(1);
        end

        if (free) begin
            if (hold_valid_q) begin
                sreg_d       = hold_q;
                cnt_d        = '0;
                state_d      = SHIFT;
                hold_valid_d = 1'b0;
            end else if (accept) begin
                sreg_d  = bus.data_in;
                cnt_d   = '0;
                state_d = SHIFT;
            end else begin
                state_d = IDLE;
            end
        end else if (accept) begin
            hold_d       = bus.data_in;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            hold_q       <= '0;
            cnt_q        <= '0;
            hold_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            hold_valid_q <= hold_valid_d;
            word_done_q  <= word_done_d;
        end
    end
endmodule

// File: tb/tb_coding_bit_serializer.sv
// Drives an LSB-first and an MSB-first serializer with the same stimulus and
// checks both every cycle against a word-queue reference model.
module tb_coding_bit_serializer;
    localparam int W = 16;

    logic clk;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    coding_bit_serializer_if #(.WIDTH(W)) bus_lsb ();
    coding_bit_serializer_if #(.WIDTH(W)) bus_msb ();

    coding_bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_lsb.slave)
    );

    coding_bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_msb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: words in flight (current one first, then the held one)
    logic [W-1:0] words[$];
    int           front_idx = 0;
    logic         exp_done  = 1'b0;

    // Per-scenario observation of the serial stream
    int           wr_cycles;
    logic [W-1:0] seq_lsb;
    logic [W-1:0] seq_msb;
    int           step_no;
    int           done_step;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic expBit(input bit lsb);
        if (words.size() == 0) return 1'b0;
        return lsb ? words[0][front_idx] : words[0][W-1-front_idx];
    endfunction

    function automatic logic expWrreq(input logic qf);
        return (words.size() > 0) && !qf;
    endfunction

    task automatic modelReset();
        words.delete();
        front_idx = 0;
        exp_done  = 1'b0;
    endtask

    task automatic modelStep(input logic valid, input logic [W-1:0] data, input logic qf);
        logic acc;
        logic done;
        acc  = valid && (words.size() < 2);
        done = 1'b0;
        if (words.size() > 0 && !qf) begin
            front_idx++;
            if (front_idx == W) begin
                void'(words.pop_front());
                front_idx = 0;
                done      = 1'b1;
            end
        end
        if (acc) words.push_back(data);
        exp_done = done;
    endtask

    task automatic checkOutput(input logic qf);
        check("lsb.data_ready", bus_lsb.data_ready, words.size() < 2);
        check("lsb.wrreq",      bus_lsb.wrreq,      expWrreq(qf));
        check("lsb.bit_output", bus_lsb.bit_output, expBit(1'b1));
        check("lsb.busy",       bus_lsb.busy,       words.size() > 0);
        check("lsb.word_done",  bus_lsb.word_done,  exp_done);
        check("msb.data_ready", bus_msb.data_ready, words.size() < 2);
        check("msb.wrreq",      bus_msb.wrreq,      expWrreq(qf));
        check("msb.bit_output", bus_msb.bit_output, expBit(1'b0));
        check("msb.busy",       bus_msb.busy,       words.size() > 0);
        check("msb.word_done",  bus_msb.word_done,  exp_done);
        if (bus_lsb.wrreq) begin
            if (wr_cycles < W) begin
                seq_lsb[wr_cycles]       = bus_lsb.bit_output;
                seq_msb[W-1-wr_cycles]   = bus_msb.bit_output;
            end
            wr_cycles++;
        end
        if (bus_lsb.word_done && done_step < 0) done_step = step_no;
    endtask

    // One clock: drive at the falling edge, check, then advance the model at the rising edge
    task automatic applyStimulus(input logic valid, input logic [W-1:0] data, input logic qf);
        bus_lsb.data_valid = valid;
        bus_lsb.data_in    = data;
        bus_lsb.queue_full = qf;
        bus_msb.data_valid = valid;
        bus_msb.data_in    = data;
        bus_msb.queue_full = qf;
        #1;
        checkOutput(qf);
        step_no++;
        @(posedge clk);
        modelStep(valid, data, qf);
        @(negedge clk);
    endtask

    task automatic startScenario();
        wr_cycles = 0;
        seq_lsb   = '0;
        seq_msb   = '0;
        step_no   = 0;
        done_step = -1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_lsb.data_valid = 1'b0;
        bus_lsb.data_in    = '0;
        bus_lsb.queue_full = 1'b0;
        bus_msb.data_valid = 1'b0;
        bus_msb.data_in    = '0;
        bus_msb.queue_full = 1'b0;
        modelReset();
        startScenario();

        @(negedge clk);
        #1;
        check("reset.data_ready", bus_lsb.data_ready, 1'b1);
        check("reset.wrreq",      bus_lsb.wrreq,      1'b0);
        check("reset.bit_output", bus_lsb.bit_output, 1'b0);
        check("reset.busy",       bus_lsb.busy,       1'b0);
        check("reset.word_done",  bus_lsb.word_done,  1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, no stalls
        startScenario();
        applyStimulus(1'b1, 16'hF03C, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 16'h1234, 1'b0);
        check("single.wr_cycles", wr_cycles, 16);
        check("single.seq_lsb",   seq_lsb,   16'hF03C);
        check("single.seq_msb",   seq_msb,   16'hF03C);
        check("single.done_step", done_step, 17);

        // Two words back to back
        startScenario();
        applyStimulus(1'b1, 16'hF03C, 1'b0);
        applyStimulus(1'b1, 16'h00FF, 1'b0);
        for (int i = 0; i < 36; i++) applyStimulus(1'b0, 16'hAAAA, 1'b0);
        check("stream.wr_cycles", wr_cycles, 32);
        check("stream.first_seq", seq_lsb,   16'hF03C);

        // Three-cycle stall starting at bit 5
        startScenario();
        applyStimulus(1'b1, 16'hF03C, 1'b0);
        for (int i = 1; i < 24; i++)
            applyStimulus(1'b0, 16'h5555, (i >= 6 && i <= 8));
        check("stall.wr_cycles", wr_cycles, 16);
        check("stall.seq_lsb",   seq_lsb,   16'hF03C);
        check("stall.seq_msb",   seq_msb,   16'hF03C);
        check("stall.done_step", done_step, 20);

        // Reset during bit 8 with a second word held
        startScenario();
        applyStimulus(1'b1, 16'hC3A5, 1'b0);
        applyStimulus(1'b1, 16'h1F2E, 1'b0);
        for (int i = 2; i < 9; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset.wrreq",      bus_lsb.wrreq,      1'b0);
        check("midreset.busy",       bus_lsb.busy,       1'b0);
        check("midreset.word_done",  bus_lsb.word_done,  1'b0);
        check("midreset.data_ready", bus_lsb.data_ready, 1'b1);
        check("midreset.msb_wrreq",  bus_msb.wrreq,      1'b0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        startScenario();
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 16'hFFFF, 1'b0);
        check("postreset.wr_cycles", wr_cycles, 0);

        // Valid held with changing data while the holding register is full
        for (int i = 0; i < 60; i++)
            applyStimulus(1'b1, W'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 16'h0000, 1'b0);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 600; i++)
            applyStimulus(($urandom_range(0, 3) != 0), W'($urandom),
                          ($urandom_range(0, 3) == 0));
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
        check("drain.busy", bus_lsb.busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/coding_bit_serializer.md
# coding_bit_serializer

Parallel-to-serial front end for `coding_queue`. It accepts WIDTH-bit words from the data source through a valid/ready handshake and emits them one bit per clock as `bit_output`/`wrreq`, the pair that `coding_queue` consumes. It stalls on `queue_full`. A one-word holding register lets the next word be accepted while the current one shifts out, so consecutive words stream with no bubble.

## Interface
- `WIDTH`, default 16: bits per input word, minimum 2.
- `LSB_FIRST`, default 1: 1 sends `data_in[0]` first; 0 sends `data_in[WIDTH-1]` first.

- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  WIDTH  parallel word from the source.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  block can accept a word this cycle.
- `queue_full`  in  1  `coding_queue` cannot take a bit this cycle.
- `bit_output`  out  1  current serial bit; connects to `coding_queue.bit_input`.
- `wrreq`  out  1  write strobe to `coding_queue`; one bit is transferred per cycle it is high at a rising edge.
- `busy`  out  1  a word is shifting or held.
- `word_done`  out  1  one-cycle pulse after the last bit of a word is written.

## Operation
- State: FSM {IDLE, SHIFT}, shift register `sreg[WIDTH]`, bit counter `cnt` ($clog2(WIDTH) bits, 0..WIDTH-1), holding register `hold[WIDTH]` with `hold_valid`.
- Combinational outputs:
  - `data_ready` = !`hold_valid`.
  - `wrreq` = (state==SHIFT) && !`queue_full`.
  - `bit_output` = `sreg[0]` when LSB_FIRST, else `sreg[WIDTH-1]`; forced to 0 in IDLE.
  - `busy` = (state==SHIFT) || `hold_valid`.
- `accept` = `data_valid` && `data_ready`.
- `last` = `wrreq` && (`cnt`==WIDTH-1).
- `free` = (state==IDLE) || `last`.
- On each edge:
  - If `wrreq` && !`last`: shift `sreg` by one toward the output end and increment `cnt`.
  - If `free`:
    - If `hold_valid`: load `sreg`<=`hold`, set `cnt`<=0, go to SHIFT, clear `hold_valid`. No accept is possible in this case because `data_ready` is low.
    - Else if `accept`: load `sreg`<=`data_in`, set `cnt`<=0, go to SHIFT. This is the bypass path; `hold` is untouched.
    - Else: go to IDLE.
  - If !`free` && `accept`: `hold`<=`data_in`, `hold_valid`<=1.
- `word_done` is registered and set for one cycle on the edge after `last`.
- `queue_full` freezes `sreg`, `cnt` and `bit_output`. `wrreq` drops in the same cycle. The holding register may still fill.
- A word is never truncated. It is dropped only by reset.

## Timing
- Reset values:
  - `state`=IDLE, `cnt`=0, `sreg`=0, `hold`=0, `hold_valid`=0, `word_done`=0.
  - Outputs therefore read `data_ready`=1, `wrreq`=0, `bit_output`=0, `busy`=0.
- Reset asserted mid-word: `wrreq` falls asynchronously with `rst_n`, and the remaining bits and any held word are discarded.
- Latency when idle:
  - Word accepted at edge E0.
  - First bit has `wrreq`=1 from E0 to E1.
  - With no stalls, bit k is written at edge E(k+1).
  - The last bit is written at E(WIDTH); `word_done` is high between E(WIDTH) and E(WIDTH+1).
- Throughput: with `data_valid` held high and a new word always available, output is 1 bit/cycle indefinitely.
  - Word 2 is accepted into `hold` at E1.
  - `data_ready` stays low until `hold` transfers to `sreg` on the last-bit edge of word 1.
- Each stall cycle delays all later bits and `word_done` by exactly one cycle.
- Simultaneous `last` and `accept` with `hold` empty: the incoming word goes straight to `sreg`. Its first bit follows the previous last bit with no gap.
- `data_in` is sampled only on an accept edge. Changes at other times have no effect.

## Test plan
- Reset, then drive `data_in`=16'hF03C with `data_valid` for 1 cycle, `queue_full`=0 -> `wrreq` high 16 cycles; `bit_output` sequence 0,0,1,1,1,1,0,0,0,0,0,0,1,1,1,1; `word_done` one pulse; `busy` returns to 0.
- Same word with LSB_FIRST=0 -> sequence 1,1,1,1,0,0,0,0,0,0,1,1,1,1,0,0.
- Words 16'hF03C then 16'h00FF, `data_valid` held -> 32 contiguous `wrreq` cycles with no gap; `data_ready` low from E1 until the 16th bit edge; two `word_done` pulses 16 cycles apart.
- `queue_full` high for 3 cycles starting at bit 5 of 16'hF03C -> `wrreq` low for those 3 cycles; `bit_output` holds 1; total transfer takes 19 cycles; bit sequence unchanged.
- `rst_n` pulsed low at bit 8 of a word with a second word held -> `wrreq`, `busy` and `word_done` go to 0 immediately; `data_ready`=1; no further bits after release.
- With `hold` full, `data_valid` stays high with a changing `data_in` -> no accept while `data_ready`=0; the third word is captured only after the `hold`→`sreg` transfer.
